// File: rtl/clkdiv_pkg.sv
// Shared defaults and types for clk_divider_multi.
// The optional tick output is enabled by defining CLKDIV_TICK_EN.
package clkdiv_pkg;

  localparam int CLKDIV_N_CH  = 4;
  localparam int CLKDIV_DIV_W = 8;
  localparam logic [CLKDIV_N_CH*CLKDIV_DIV_W-1:0] CLKDIV_DIV_INIT =
    {8'd100, 8'd10, 8'd3, 8'd2};

  typedef logic [CLKDIV_DIV_W-1:0] div_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divided-clock channel: counter, shadow/active divisor, registered outputs.
// Tick register exists only when CLKDIV_TICK_EN is defined.
module clkdiv_channel #(
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] shd_q, shd_d;
  logic             pend_q, pend_d;
  logic             run_q, run_d;
  logic             clk_q, clk_d;
  logic             idle, wrap, apply;

  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] d);
    return ({1'b0, d} + (DIV_W+1)'(1)) >> 1;
  endfunction

  // run_q holds clk_out low after idling until the first complete count wraps.
  always_comb begin
    idle   = !en || (act_q < DIV_W'(2));
    wrap   = !idle && (cnt_q == act_q - DIV_W'(1));
    apply  = pend_q && (idle || wrap);
    act_d  = apply ? shd_q : act_q;
    shd_d  = wr ? wr_div : shd_q;
    pend_d = wr || (pend_q && !apply);
    cnt_d  = (idle || wrap) ? '0 : cnt_q + DIV_W'(1);
    run_d  = !idle && (run_q || wrap) && (act_d >= DIV_W'(2));
    clk_d  = run_d && ({1'b0, cnt_d} < high_len(act_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      act_q  <= DIV_INIT;
      shd_q  <= DIV_INIT;
      pend_q <= 1'b0;
      run_q  <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      run_q  <= run_d;
      clk_q  <= clk_d;
    end
  end

  assign clk_out = clk_q;
  assign pending = pend_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = run_d && wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= tick_d;
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel glitch-free clock divider: write decode plus N_CH channel instances.
// Define CLKDIV_TICK_EN to enable the per-channel tick pulse output.
module clk_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int                     N_CH     = CLKDIV_N_CH,
  parameter int                     DIV_W    = CLKDIV_DIV_W,
  parameter logic [N_CH*DIV_W-1:0]  DIV_INIT = CLKDIV_DIV_INIT,
  localparam int                    CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clock_100M,
  input  logic              reset,
  input  logic [N_CH-1:0]   en,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [N_CH-1:0]   clk_out,
  output logic [N_CH-1:0]   tick,
  output logic [N_CH-1:0]   cfg_pending
);

  logic [N_CH-1:0] wr_sel;

  // Channel indices at or above N_CH match no channel, so such writes drop out.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (cfg_we && (int'(cfg_ch) == i)) wr_sel[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clkdiv_channel #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT[g*DIV_W +: DIV_W])
    ) u_ch (
      .clk     (clock_100M),
      .rst_n   (reset),
      .en      (en[g]),
      .wr      (wr_sel[g]),
      .wr_div  (cfg_div),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (cfg_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed and randomized bench for clk_divider_multi against an elapsed-time reference model.
module tb_clk_divider_multi;

  localparam int N_CH  = 4;
  localparam int DIV_W = 8;
  localparam int CH_W  = 2;

  logic                clock_100M = 1'b0;
  logic                reset      = 1'b1;
  logic [N_CH-1:0]     en         = '0;
  logic                cfg_we     = 1'b0;
  logic [CH_W-1:0]     cfg_ch     = '0;
  logic [DIV_W-1:0]    cfg_div    = '0;
  logic [N_CH-1:0]     clk_out, tick, cfg_pending;

  int errors = 0;
  int checks = 0;

  logic [31:0] init_v = {8'd100, 8'd10, 8'd3, 8'd2};

  // Model state: active/shadow divisor, edges elapsed in current period,
  // whether a full period has completed since the channel went live.
  int m_d[N_CH], m_shd[N_CH], m_e[N_CH];
  bit m_pend[N_CH], m_start[N_CH], m_wrap[N_CH];

  always #5 clock_100M = ~clock_100M;

  clk_divider_multi dut (
    .clock_100M  (clock_100M),
    .reset       (reset),
    .en          (en),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_out     (clk_out),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_d[i]     = int'(init_v[i*8 +: 8]);
      m_shd[i]   = m_d[i];
      m_e[i]     = 0;
      m_pend[i]  = 1'b0;
      m_start[i] = 1'b0;
      m_wrap[i]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < N_CH; i++) begin
      bit live, wrp, app;
      live = en[i] && (m_d[i] >= 2);
      wrp  = 1'b0;
      if (live) begin
        m_e[i] = m_e[i] + 1;
        if (m_e[i] == m_d[i]) begin
          m_e[i]     = 0;
          wrp        = 1'b1;
          m_start[i] = 1'b1;
        end
      end else begin
        m_e[i]     = 0;
        m_start[i] = 1'b0;
      end
      app = m_pend[i] && (!live || wrp);
      if (app) begin
        m_d[i]    = m_shd[i];
        m_pend[i] = 1'b0;
        if (m_d[i] < 2) m_start[i] = 1'b0;
      end
      if (cfg_we && (int'(cfg_ch) == i)) begin
        m_shd[i]  = int'(cfg_div);
        m_pend[i] = 1'b1;
      end
      m_wrap[i] = wrp && (m_d[i] >= 2);
    end
  endtask

  task automatic check(input string tag);
    logic [N_CH-1:0] ec, et, ep;
    for (int i = 0; i < N_CH; i++) begin
      ec[i] = m_start[i] && (m_d[i] >= 2) && (m_e[i] < (m_d[i] + 1) / 2);
`ifdef CLKDIV_TICK_EN
      et[i] = m_wrap[i];
`else
      et[i] = 1'b0;
`endif
      ep[i] = m_pend[i];
    end
    checks++;
    assert (clk_out === ec) else begin
      errors++; $error("FAIL %s clk_out got %b want %b", tag, clk_out, ec);
    end
    checks++;
    assert (tick === et) else begin
      errors++; $error("FAIL %s tick got %b want %b", tag, tick, et);
    end
    checks++;
    assert (cfg_pending === ep) else begin
      errors++; $error("FAIL %s cfg_pending got %b want %b", tag, cfg_pending, ep);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  task automatic step(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clock_100M);
      model_edge();
      #1;
      check(tag);
    end
  endtask

  task automatic write(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = CH_W'(ch);
    cfg_div = DIV_W'(div);
  endtask

  task automatic wait_e(input int ch, input int val, input string tag);
    int k;
    k = 0;
    while (m_e[ch] != val && k < 300) begin
      step(1, tag);
      k++;
    end
    checks++;
    assert (k < 300) else begin
      errors++; $error("FAIL %s wait timeout phase got %0d want %0d", tag, m_e[ch], val);
    end
  endtask

  initial begin
    int k;
    model_reset();

    // Reset asserted, held across edges
    #2 reset = 1'b0;
    #1 check("reset_async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clock_100M);
      #1 check("reset_hold");
    end

    // Defaults with all channels enabled
    en = 4'b1111;
    #2 reset = 1'b1;
    step(1, "first_edge");
    chk_bit("first_edge_ch0_low", clk_out[0], 1'b0);
    step(1, "ch0_rise");
    chk_bit("ch0_rise", clk_out[0], 1'b1);
    step(1, "ch0_fall");
    chk_bit("ch0_fall", clk_out[0], 1'b0);
    step(215, "defaults");

    // Divisor change on ch2 mid-period
    wait_e(2, 3, "ch2_wait");
    write(2, 4);
    step(1, "ch2_write");
    cfg_we = 1'b0;
    chk_bit("ch2_pending_set", cfg_pending[2], 1'b1);
    step(40, "ch2_div4");

    // Two writes to ch3 before a wrap, then a write coincident with a wrap
    wait_e(3, 10, "ch3_wait");
    write(3, 20);
    step(1, "ch3_w20");
    cfg_we = 1'b0;
    step(5, "ch3_gap");
    write(3, 50);
    step(1, "ch3_w50");
    cfg_we = 1'b0;
    step(100, "ch3_apply50");
    wait_e(3, 49, "ch3_wait_wrap");
    write(3, 30);
    step(1, "ch3_coincident");
    cfg_we = 1'b0;
    chk_bit("ch3_deferred", cfg_pending[3], 1'b1);
    step(90, "ch3_deferred_period");

    // Drop and restore ch1 enable while its output is high
    k = 0;
    while (!(m_start[1] && m_e[1] < 2) && k < 20) begin
      step(1, "ch1_wait_high");
      k++;
    end
    chk_bit("ch1_high_before_drop", clk_out[1], 1'b1);
    en[1] = 1'b0;
    step(1, "ch1_drop");
    chk_bit("ch1_low_after_drop", clk_out[1], 1'b0);
    step(3, "ch1_off");
    en[1] = 1'b1;
    step(2, "ch1_reen");
    chk_bit("ch1_still_low", clk_out[1], 1'b0);
    step(1, "ch1_first_rise");
    chk_bit("ch1_first_rise", clk_out[1], 1'b1);
    step(12, "ch1_div3");

    // ch0 idle via divisor 1, then resume with 2
    write(0, 1);
    step(1, "ch0_w1");
    cfg_we = 1'b0;
    step(6, "ch0_idle");
    chk_bit("ch0_idle_low", clk_out[0], 1'b0);
    write(0, 2);
    step(1, "ch0_w2");
    cfg_we = 1'b0;
    step(8, "ch0_resume");

    // Async reset mid-period with a write pending
    write(3, 7);
    step(1, "pre_reset_write");
    cfg_we = 1'b0;
    step(3, "pre_reset");
    #2 reset = 1'b0;
    model_reset();
    #1 check("mid_reset");
    chk_bit("mid_reset_pend3", cfg_pending[3], 1'b0);
    @(posedge clock_100M);
    #1 check("mid_reset_hold");
    #2 reset = 1'b1;
    step(120, "post_reset");

    // Randomized enables and writes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(15) == 0) en[$urandom_range(N_CH-1)] ^= 1'b1;
      if ($urandom_range(7) == 0) write($urandom_range(N_CH-1), $urandom_range(12));
      else cfg_we = 1'b0;
      step(1, "random");
    end
    cfg_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_divider_multi.md
CLK_DIVIDER_MULTI -- requirements
Module: clk_divider_multi

Interface
REQ-001 Parameter N_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 Parameter DIV_W, default 8: divisor width in bits.
REQ-003 Parameter DIV_INIT, default {100,10,3,2}: per-channel divisor loaded at reset; channel 0 is rightmost (2 = 50 MHz, 3 = 33.3 MHz, 10 = 10 MHz, 100 = 1 MHz from 100 MHz).
REQ-004 clock_100M  input  1  sole clock for the block.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 en  input  N_CH  per-channel run enable.
REQ-007 cfg_we  input  1  one-cycle divisor write strobe.
REQ-008 cfg_ch  input  $clog2(N_CH) (min 1)  target channel of the write.
REQ-009 cfg_div  input  DIV_W  new divisor value.
REQ-010 clk_out  output  N_CH  divided clock per channel, registered.
REQ-011 tick  output  N_CH  one-cycle pulse per divided period.
REQ-012 cfg_pending  output  N_CH  shadow divisor written but not yet applied.

Function
REQ-013 Each channel SHALL hold an active divisor D, a shadow divisor, and a counter cnt running 0..D-1.
REQ-014 With en=1 and D>=2, each edge: cnt <= (cnt==D-1) ? 0 : cnt+1.
REQ-015 clk_out[i] SHALL be registered from the next cnt value: high when next cnt < ceil(D/2), low otherwise. Period = D clocks; high time = ceil(D/2) clocks. For odd D, duty is (D+1)/(2D).
REQ-016 tick[i] SHALL be high for exactly the one cycle following the cnt wrap D-1 -> 0 (same edge at which clk_out rises).
REQ-017 cfg_we=1 SHALL write cfg_div into the cfg_ch shadow and set cfg_pending[cfg_ch] at the next edge.
REQ-018 A pending shadow SHALL become active at the wrap edge (cnt D-1 -> 0) and clear cfg_pending on that edge. Divisor changes SHALL therefore never truncate a period (glitch-free).
REQ-019 If the channel is disabled, or its active D<2, a pending shadow SHALL be applied on the next edge.
REQ-020 A second write before application SHALL overwrite the shadow; only the last value applies.
REQ-021 A write in the same cycle as a wrap SHALL NOT apply at that wrap. The previous pending value, if any, applies, and the new value stays pending until the next wrap.
REQ-022 If cfg_ch >= N_CH, the write SHALL be ignored.
REQ-023 Active D of 0 or 1 SHALL idle the channel: cnt=0, clk_out=0, tick=0.
REQ-024 en[i]=0 SHALL reset cnt to 0 and drive clk_out[i]=0 and tick[i]=0 at the next edge, and SHALL preserve the divisors.
REQ-025 On re-enable, clk_out SHALL rise one edge after the first full count (cnt reaches D-1 then wraps). The first period is therefore aligned, never short.
REQ-026 Channels SHALL be fully independent; no cross-channel phase relation is guaranteed except when enabled on the same edge with equal D.

Reset
REQ-027 reset=0 SHALL asynchronously set cnt=0, clk_out=0, tick=0, cfg_pending=0, and active and shadow divisors to DIV_INIT.
REQ-028 Reset mid-period SHALL discard the partial period and any pending write.
REQ-029 After reset release, counting SHALL start on the first edge with en=1.

Configuration
REQ-030 Macro CLKDIV_TICK_EN defined: tick SHALL behave per REQ-016.
REQ-031 Macro CLKDIV_TICK_EN undefined: tick SHALL be tied to 0 and no tick logic SHALL be synthesised. All other behaviour SHALL be unchanged.

Structure
REQ-032 Package clkdiv_pkg SHALL hold the DIV_W default, the N_CH default, the DIV_INIT default, and typedef div_t (logic [DIV_W-1:0]).
REQ-033 Per-channel logic (counter, shadow, active divisor, output registers) SHALL be sub-module clkdiv_channel, instantiated N_CH times by generate loop.
REQ-034 The top level SHALL contain only write decode and instantiation.

Verification
REQ-035 Reset release with en=4'b1111 and defaults -> ch0 toggles every cycle (50 MHz), ch1 period 3 with high 2, ch2 period 10 with high 5, ch3 period 100 with high 50.
REQ-036 ch2 running D=10; write cfg_div=4 at cnt=3 -> current period completes at 10 clocks, then period 4; cfg_pending high from write+1 until the wrap edge.
REQ-037 Two writes to ch3 (20 then 50) before a wrap -> only 50 applied; write coincident with the wrap edge -> deferred one full period.
REQ-038 Drop en[1] mid-high -> clk_out[1]=0 next edge; re-raise en[1] -> first rising edge after 3 clocks; divisor still 3.
REQ-039 Write cfg_div=1 to ch0 -> ch0 idles low at the next wrap; write 2 -> resumes on the next edge per REQ-019.
REQ-040 Assert reset low mid-period with a write pending -> all outputs 0 immediately; after release, DIV_INIT restored and cfg_pending=0. With CLKDIV_TICK_EN undefined -> tick constantly 0.
